// File: rtl/fb_pkg.sv
// Shared types and constants for the rectangle-fill front end of the VGA pixel memory.
// Register indices match the software-visible register map.
package fb_pkg;

  localparam int HRES_DEF    = 640;
  localparam int VRES_DEF    = 480;
  localparam int ADDR_W_DEF  = 19;
  localparam int COORD_W_DEF = 11;

  localparam logic [3:0] REG_R    = 4'd0;
  localparam logic [3:0] REG_G    = 4'd1;
  localparam logic [3:0] REG_B    = 4'd2;
  localparam logic [3:0] REG_X_HI = 4'd3;
  localparam logic [3:0] REG_X_LO = 4'd4;
  localparam logic [3:0] REG_Y_HI = 4'd5;
  localparam logic [3:0] REG_Y_LO = 4'd6;
  localparam logic [3:0] REG_W_HI = 4'd7;
  localparam logic [3:0] REG_W_LO = 4'd8;
  localparam logic [3:0] REG_H_HI = 4'd9;
  localparam logic [3:0] REG_H_LO = 4'd10;
  localparam logic [3:0] REG_CTRL = 4'd11;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} fill_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Clips a rectangle to the visible area and walks its pixels in row-major order.
// Address is kept as row_base + cx incrementally; only the setup cycle multiplies.
module fb_rect_walker #(
  parameter int HRES    = 640,
  parameter int VRES    = 480,
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               setup_i,
  input  logic               fill_i,
  input  logic               fb_ready_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic               reject_o,
  output logic               last_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [COORD_W:0]  HRES_C = (COORD_W+1)'(HRES);
  localparam logic [COORD_W:0]  VRES_C = (COORD_W+1)'(VRES);
  localparam logic [COORD_W:0]  C_ONE  = (COORD_W+1)'(1);
  localparam logic [ADDR_W-1:0] HRES_A = ADDR_W'(HRES);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  logic [COORD_W:0]  x_ext, y_ext, xsum, ysum, xe, ye;
  logic [COORD_W:0]  cx_q, cy_q, x_last_q, y_last_q;
  logic [ADDR_W-1:0] row_base_q, addr_q, row_start;
  logic              last_col;

  // Sums carry one extra bit so X+W cannot wrap before the clip.
  assign x_ext = {1'b0, x_i};
  assign y_ext = {1'b0, y_i};
  assign xsum  = x_ext + {1'b0, w_i};
  assign ysum  = y_ext + {1'b0, h_i};
  assign xe    = (xsum > HRES_C) ? HRES_C : xsum;
  assign ye    = (ysum > VRES_C) ? VRES_C : ysum;

  assign reject_o  = (w_i == '0) || (h_i == '0) || (x_ext >= HRES_C) || (y_ext >= VRES_C);
  assign row_start = ADDR_W'(y_i) * HRES_A + ADDR_W'(x_i);

  assign last_col = (cx_q == x_last_q);
  assign last_o   = last_col && (cy_q == y_last_q);
  assign addr_o   = addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_q       <= '0;
      cy_q       <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else if (setup_i) begin
      cx_q       <= '0;
      cy_q       <= y_ext;
      x_last_q   <= xe - x_ext - C_ONE;
      y_last_q   <= ye - C_ONE;
      row_base_q <= row_start;
      addr_q     <= row_start;
    end else if (fill_i && fb_ready_i) begin
      if (last_col) begin
        cx_q       <= '0;
        cy_q       <= cy_q + C_ONE;
        row_base_q <= row_base_q + HRES_A;
        addr_q     <= row_base_q + HRES_A;
      end else begin
        cx_q   <= cx_q + C_ONE;
        addr_q <= addr_q + A_ONE;
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Avalon-MM register front end that streams clipped rectangle fills into the VGA pixel memory.
// One pixel per clock while fb_ready is high; address and data hold while it is low.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int HRES    = HRES_DEF,
  parameter int VRES    = VRES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [3:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              fb_write_ena,
  output logic [ADDR_W-1:0] fb_address_write,
  output logic [23:0]       fb_data_in,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done
);

  localparam int HI_W = COORD_W - 8;

  fill_state_t        state_q, state_d;
  rgb_t               rgb_q, wrgb_q;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
  logic [COORD_W-1:0] wx_q, wy_q, ww_q, wh_q;
  logic               done_sticky_q;
  logic [7:0]         readdata_q, rd_mux;
  logic               wr, start, rd_ctrl, reject, last;

  assign wr      = chipselect && write;
  assign start   = wr && (address == REG_CTRL) && writedata[0];
  assign rd_ctrl = chipselect && read && (address == REG_CTRL);

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign fb_write_ena = (state_q == FILL);
  assign fb_data_in   = wrgb_q;
  assign readdata     = readdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '{r: 8'h00, g: 8'h00, b: 8'h80};
      x_q   <= '0;
      y_q   <= '0;
      w_q   <= '0;
      h_q   <= '0;
    end else if (wr) begin
      case (address)
        REG_R:    rgb_q.r <= writedata;
        REG_G:    rgb_q.g <= writedata;
        REG_B:    rgb_q.b <= writedata;
        REG_X_HI: x_q[COORD_W-1:8] <= writedata[HI_W-1:0];
        REG_X_LO: x_q[7:0] <= writedata;
        REG_Y_HI: y_q[COORD_W-1:8] <= writedata[HI_W-1:0];
        REG_Y_LO: y_q[7:0] <= writedata;
        REG_W_HI: w_q[COORD_W-1:8] <= writedata[HI_W-1:0];
        REG_W_LO: w_q[7:0] <= writedata;
        REG_H_HI: h_q[COORD_W-1:8] <= writedata[HI_W-1:0];
        REG_H_LO: h_q[7:0] <= writedata;
        default:  ;
      endcase
    end
  end

  // Working copies are frozen at start so shadow writes never disturb a fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrgb_q <= '0;
      wx_q   <= '0;
      wy_q   <= '0;
      ww_q   <= '0;
      wh_q   <= '0;
    end else if ((state_q == IDLE) && start) begin
      wrgb_q <= rgb_q;
      wx_q   <= x_q;
      wy_q   <= y_q;
      ww_q   <= w_q;
      wh_q   <= h_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = reject ? FINISH : FILL;
      FILL:    if (fb_ready && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_R:    rd_mux = rgb_q.r;
      REG_G:    rd_mux = rgb_q.g;
      REG_B:    rd_mux = rgb_q.b;
      REG_X_HI: rd_mux = 8'(x_q[COORD_W-1:8]);
      REG_X_LO: rd_mux = x_q[7:0];
      REG_Y_HI: rd_mux = 8'(y_q[COORD_W-1:8]);
      REG_Y_LO: rd_mux = y_q[7:0];
      REG_W_HI: rd_mux = 8'(w_q[COORD_W-1:8]);
      REG_W_LO: rd_mux = w_q[7:0];
      REG_H_HI: rd_mux = 8'(h_q[COORD_W-1:8]);
      REG_H_LO: rd_mux = h_q[7:0];
      REG_CTRL: rd_mux = {6'b0, done_sticky_q | done, busy};
      default:  rd_mux = '0;
    endcase
  end

  // A CTRL read in the FINISH cycle still reports done, then clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q    <= '0;
      done_sticky_q <= 1'b0;
    end else begin
      if (chipselect && read) readdata_q <= rd_mux;
      if (rd_ctrl)                done_sticky_q <= 1'b0;
      else if (state_q == FINISH) done_sticky_q <= 1'b1;
    end
  end

  fb_rect_walker #(
    .HRES(HRES), .VRES(VRES), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) u_walker (
    .clk       (clk),
    .reset_n   (reset_n),
    .setup_i   (state_q == SETUP),
    .fill_i    (state_q == FILL),
    .fb_ready_i(fb_ready),
    .x_i       (wx_q),
    .y_i       (wy_q),
    .w_i       (ww_q),
    .h_i       (wh_q),
    .reject_o  (reject),
    .last_o    (last),
    .addr_o    (fb_address_write)
  );

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed and random rectangles checked against a clip-and-loop model.
module tb_fb_rect_fill;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [3:0]  address = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  readdata;
  logic        fb_write_ena, fb_ready = 1'b1, busy, done;
  logic [18:0] fb_address_write;
  logic [23:0] fb_data_in;

  fb_rect_fill dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .fb_write_ena(fb_write_ena), .fb_address_write(fb_address_write), .fb_data_in(fb_data_in),
    .fb_ready(fb_ready), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int stall_lo = -1, stall_hi = -1;
  bit rand_rdy = 1'b0;
  int acc_addr[$], acc_data[$], acc_cyc[$], ena_addr[$], done_cyc[$];

  initial forever begin
    @(posedge clk);
    #2;
    fb_ready = !(cyc >= stall_lo && cyc <= stall_hi) && (!rand_rdy || ($urandom_range(0, 3) != 0));
  end

  initial forever begin
    @(negedge clk);
    if (fb_write_ena) begin
      ena_addr.push_back(int'(fb_address_write));
      if (fb_ready) begin
        acc_addr.push_back(int'(fb_address_write));
        acc_data.push_back(int'(fb_data_in));
        acc_cyc.push_back(cyc);
      end
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete(); acc_cyc.delete(); ena_addr.delete(); done_cyc.delete();
  endtask

  task automatic avw(input logic [3:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(posedge clk); #2;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic avr(input logic [3:0] a, output int v);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(posedge clk); #2;
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    v = int'(readdata);
    @(posedge clk); #2;
  endtask

  task automatic rect(input int x, input int y, input int w, input int h, input int rgb);
    avw(4'd0, 8'(rgb >> 16)); avw(4'd1, 8'(rgb >> 8)); avw(4'd2, 8'(rgb));
    avw(4'd3, 8'(x >> 8)); avw(4'd4, 8'(x));
    avw(4'd5, 8'(y >> 8)); avw(4'd6, 8'(y));
    avw(4'd7, 8'(w >> 8)); avw(4'd8, 8'(w));
    avw(4'd9, 8'(h >> 8)); avw(4'd10, 8'(h));
  endtask

  task automatic start_fill(output int n);
    clear_logs();
    n = cyc;
    avw(4'd11, 8'h01);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cyc.size() != 0) begin ok = 1'b1; break; end
    end
    chk({tag, " done within budget"}, int'(ok), 1);
    @(posedge clk); #2;
  endtask

  // Reference: every visible pixel of the rectangle, row-major, one accepted write each.
  task automatic check_fill(input string tag, input int x, input int y, input int w, input int h,
                            input int rgb, input int n, input bit consec);
    int exp_a[$];
    int bad_a = 0, bad_d = 0, bad_c = 0, exp_done;
    for (int yy = y; yy < y + h && yy < 480; yy++)
      for (int xx = x; xx < x + w && xx < 640; xx++)
        exp_a.push_back(yy * 640 + xx);
    chk({tag, " write count"}, acc_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < acc_addr.size(); i++) begin
      if (acc_addr[i] != exp_a[i]) bad_a++;
      if (acc_data[i] != (rgb & 32'hFFFFFF)) bad_d++;
      if (consec && acc_cyc[i] != n + 2 + i) bad_c++;
    end
    chk({tag, " bad addresses"}, bad_a, 0);
    chk({tag, " bad data"}, bad_d, 0);
    if (consec) chk({tag, " non-consecutive writes"}, bad_c, 0);
    exp_done = (exp_a.size() == 0) ? n + 2 : ((acc_cyc.size() != 0) ? acc_cyc[$] + 1 : -2);
    chk({tag, " done cycle"}, (done_cyc.size() != 0) ? done_cyc[0] : -1, exp_done);
  endtask

  initial begin
    int n, v, x, y, w, h, c;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst readdata", int'(readdata), 0);
    chk("rst fb_write_ena", int'(fb_write_ena), 0);
    chk("rst fb_address_write", int'(fb_address_write), 0);
    chk("rst fb_data_in", int'(fb_data_in), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    avr(4'd2, v); chk("rst B register", v, 8'h80);
    avr(4'd11, v); chk("rst CTRL", v, 0);
    avr(4'd13, v); chk("unused reg read", v, 0);

    // Single pixel with exact cycle timing
    rect(10, 2, 1, 1, 24'hFF00FF);
    start_fill(n);
    @(negedge clk);
    chk("px N+1 busy", int'(busy), 1);
    chk("px N+1 ena", int'(fb_write_ena), 0);
    @(negedge clk);
    chk("px N+2 ena", int'(fb_write_ena), 1);
    chk("px N+2 addr", int'(fb_address_write), 1290);
    chk("px N+2 data", int'(fb_data_in), 24'hFF00FF);
    @(negedge clk);
    chk("px N+3 done", int'(done), 1);
    chk("px N+3 busy", int'(busy), 1);
    chk("px N+3 ena", int'(fb_write_ena), 0);
    @(negedge clk);
    chk("px N+4 busy", int'(busy), 0);
    @(posedge clk); #2;
    check_fill("px", 10, 2, 1, 1, 24'hFF00FF, n, 1'b1);
    avr(4'd11, v); chk("ctrl sticky set", v, 2);
    avr(4'd11, v); chk("ctrl sticky cleared", v, 0);

    // 3x2 and clipped corner
    rect(0, 0, 3, 2, 24'h0A0B0C); start_fill(n); wait_done("3x2", 100);
    check_fill("3x2", 0, 0, 3, 2, 24'h0A0B0C, n, 1'b1);
    rect(638, 479, 5, 5, 24'h123ABC); start_fill(n); wait_done("clip", 100);
    check_fill("clip", 638, 479, 5, 5, 24'h123ABC, n, 1'b1);

    // Rejected fills
    rect(5, 5, 0, 3, 24'h777777); start_fill(n); wait_done("w0", 100);
    check_fill("w0", 5, 5, 0, 3, 24'h777777, n, 1'b0);
    rect(700, 5, 4, 3, 24'h777777); start_fill(n); wait_done("x700", 100);
    check_fill("x700", 700, 5, 4, 3, 24'h777777, n, 1'b0);

    // Backpressure on the first pixel for three cycles
    rect(0, 0, 2, 1, 24'h00FF00);
    clear_logs();
    n = cyc; stall_lo = n + 2; stall_hi = n + 4;
    avw(4'd11, 8'h01);
    wait_done("bp", 100);
    stall_lo = -1; stall_hi = -1;
    chk("bp ena cycles", ena_addr.size(), 5);
    for (int i = 0; i < 5 && i < ena_addr.size(); i++)
      chk($sformatf("bp ena addr %0d", i), ena_addr[i], (i < 4) ? 0 : 1);
    check_fill("bp", 0, 0, 2, 1, 24'h00FF00, n, 1'b0);

    // Random rectangles, half of them with random backpressure
    for (int t = 0; t < 8; t++) begin
      x = (t % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(600, 700));
      y = (t % 3 == 0) ? int'($urandom_range(470, 500)) : int'($urandom_range(0, 30));
      w = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 6));
      c = int'($urandom_range(0, 32'hFFFFFF));
      rand_rdy = t[0];
      rect(x, y, w, h, c); start_fill(n); wait_done($sformatf("rnd%0d", t), 2000);
      check_fill($sformatf("rnd%0d", t), x, y, w, h, c, n, !rand_rdy);
    end
    rand_rdy = 1'b0;

    // Shadow writes and a second start during a large fill
    rect(5, 5, 100, 100, 24'h123456); start_fill(n);
    repeat (40) @(posedge clk);
    #2;
    avw(4'd0, 8'h11);
    avw(4'd11, 8'h01);
    wait_done("big", 20000);
    repeat (5) @(negedge clk);
    chk("big busy after", int'(busy), 0);
    chk("big done pulses", done_cyc.size(), 1);
    @(posedge clk); #2;
    check_fill("big", 5, 5, 100, 100, 24'h123456, n, 1'b1);
    avr(4'd0, v); chk("big R shadow", v, 8'h11);

    // Reset in the middle of a fill
    rect(0, 0, 100, 100, 24'h445566); start_fill(n);
    repeat (30) @(posedge clk);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst mid ena", int'(fb_write_ena), 0);
    chk("rst mid busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("rst mid no done", done_cyc.size(), 0);
    chk("rst mid partial", int'(acc_addr.size() > 0 && acc_addr.size() < 10000), 1);
    @(posedge clk); #2;
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
